// File: rtl/gray_step_checker_if.sv
// Bus between the Gray counter stage and its step checker: sample handshake in, decoded status out.
interface gray_step_checker_if #(
    parameter int unsigned W     = 3,
    parameter int unsigned CNT_W = 8
);
    logic             g_valid;
    logic [W-1:0]     g_in;
    logic             clr_err;
    logic [W-1:0]     b_out;
    logic             b_valid;
    logic             dir_up;
    logic             dir_down;
    logic             step_err;
    logic [CNT_W-1:0] err_cnt;
    logic             locked;

    modport master (
        output g_valid, g_in, clr_err,
        input  b_out, b_valid, dir_up, dir_down, step_err, err_cnt, locked
    );

    modport slave (
        input  g_valid, g_in, clr_err,
        output b_out, b_valid, dir_up, dir_down, step_err, err_cnt, locked
    );
endinterface

// File: rtl/gray_step_checker.sv
// Decodes a Gray-coded sample stream, checks every new value is one step from the last,
// and latches a fault after ERR_LIMIT consecutive illegal steps.
module gray_step_checker #(
    parameter int unsigned W         = 3,
    parameter int unsigned ERR_LIMIT = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    gray_step_checker_if.slave bus
);
    localparam int unsigned   BadW     = $clog2(ERR_LIMIT + 1);
    localparam logic [BadW-1:0] BadLimit = BadW'(ERR_LIMIT);

    typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

    state_e           state_q;
    logic             locked_q;
    logic [W-1:0]     b_out_q;
    logic             b_valid_q;
    logic             dir_up_q;
    logic             dir_down_q;
    logic             step_err_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [BadW-1:0]  bad_q;

    logic [W-1:0]     dec;
    logic             is_hold;
    logic             is_up;
    logic             is_down;
    logic [BadW-1:0]  bad_inc;

    // Binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        dec = '0;
        for (int i = 0; i < W; i++) begin
            dec[i] = ^(bus.g_in >> i);
        end
    end

    always_comb begin
        is_hold = (dec == b_out_q);
        is_up   = (dec == b_out_q + W'(1));
        is_down = (dec == b_out_q - W'(1));
        bad_inc = bad_q + BadW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            locked_q   <= 1'b0;
            b_out_q    <= '0;
            b_valid_q  <= 1'b0;
            dir_up_q   <= 1'b0;
            dir_down_q <= 1'b0;
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
            bad_q      <= '0;
        end else begin
            b_valid_q  <= 1'b0;
            dir_up_q   <= 1'b0;
            dir_down_q <= 1'b0;
            step_err_q <= 1'b0;
            // Clear wins over a coincident sample, which is dropped; b_out is kept.
            if (bus.clr_err) begin
                state_q   <= StIdle;
                locked_q  <= 1'b0;
                err_cnt_q <= '0;
                bad_q     <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (bus.g_valid) begin
                            b_out_q   <= dec;
                            b_valid_q <= 1'b1;
                            state_q   <= StTrack;
                            locked_q  <= 1'b1;
                        end
                    end
                    StTrack: begin
                        if (bus.g_valid) begin
                            b_out_q   <= dec;
                            b_valid_q <= 1'b1;
                            if (is_hold) begin
                                bad_q <= '0;
                            end else if (is_up) begin
                                dir_up_q <= 1'b1;
                                bad_q    <= '0;
                            end else if (is_down) begin
                                dir_down_q <= 1'b1;
                                bad_q      <= '0;
                            end else begin
                                step_err_q <= 1'b1;
                                if (err_cnt_q != '1) begin
                                    err_cnt_q <= err_cnt_q + CNT_W'(1);
                                end
                                bad_q <= bad_inc;
                                if (bad_inc >= BadLimit) begin
                                    state_q  <= StFault;
                                    locked_q <= 1'b0;
                                end
                            end
                        end
                    end
                    StFault: begin
                        // Samples are ignored until clr_err.
                    end
                    default: begin
                        state_q  <= StIdle;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.b_out    = b_out_q;
    assign bus.b_valid  = b_valid_q;
    assign bus.dir_up   = dir_up_q;
    assign bus.dir_down = dir_down_q;
    assign bus.step_err = step_err_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.locked   = locked_q;
endmodule

// File: tb/tb_gray_step_checker.sv
// Directed bench for gray_step_checker: abstract model compared every cycle plus literal spot checks.
module tb_gray_step_checker;
    localparam int W         = 3;
    localparam int ERR_LIMIT = 2;
    localparam int CNT_W     = 8;
    localparam int MODN      = 1 << W;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    gray_step_checker_if #(.W(W), .CNT_W(CNT_W)) bus ();

    gray_step_checker #(
        .W        (W),
        .ERR_LIMIT(ERR_LIMIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: 0 = waiting for first sample, 1 = tracking, 2 = faulted
    int m_mode = 0;
    int m_prev = 0;
    int m_errs = 0;
    int m_bad  = 0;
    bit e_bv, e_up, e_dn, e_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int gdec(input int g);
        int b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic void model_step(input bit r, input bit gv, input int g, input bit clr);
        int n;
        int d;
        e_bv = 0; e_up = 0; e_dn = 0; e_err = 0;
        if (!r) begin
            m_mode = 0; m_prev = 0; m_errs = 0; m_bad = 0;
        end else if (clr) begin
            m_mode = 0; m_errs = 0; m_bad = 0;
        end else if (gv && m_mode == 0) begin
            m_prev = gdec(g);
            e_bv = 1;
            m_mode = 1;
        end else if (gv && m_mode == 1) begin
            n = gdec(g);
            d = (n - m_prev + MODN) % MODN;
            e_bv = 1;
            if (d == 0) m_bad = 0;
            else if (d == 1) begin e_up = 1; m_bad = 0; end
            else if (d == MODN - 1) begin e_dn = 1; m_bad = 0; end
            else begin
                e_err = 1;
                if (m_errs < CNT_MAX) m_errs++;
                m_bad++;
                if (m_bad >= ERR_LIMIT) m_mode = 2;
            end
            m_prev = n;
        end
    endfunction

    task automatic cyc(input bit r, input bit gv, input logic [W-1:0] g, input bit clr);
        rst = r;
        bus.g_valid = gv;
        bus.g_in = g;
        bus.clr_err = clr;
        model_step(r, gv, int'(g), clr);
        @(posedge clk);
        #3;
    endtask

    task automatic smp(input logic [W-1:0] g);
        cyc(1'b1, 1'b1, g, 1'b0);
    endtask

    // Per-cycle compare, 1 time unit after every rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("b_out",    bus.b_out,    m_prev);
            chk("b_valid",  bus.b_valid,  e_bv);
            chk("dir_up",   bus.dir_up,   e_up);
            chk("dir_down", bus.dir_down, e_dn);
            chk("step_err", bus.step_err, e_err);
            chk("err_cnt",  bus.err_cnt,  m_errs);
            chk("locked",   bus.locked,   (m_mode == 1));
        end
    end

    logic [W-1:0] up_seq[8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    logic [W-1:0] sat_seq[4] = '{3'b110, 3'b111, 3'b001, 3'b000};

    initial begin
        // Lock-on
        cyc(1'b0, 1'b0, 3'b000, 1'b0);
        cyc(1'b0, 1'b0, 3'b000, 1'b0);
        chk("rst_bout", bus.b_out, 0);
        chk("rst_locked", bus.locked, 0);
        smp(3'b000);
        chk("lock_bout", bus.b_out, 0);
        chk("lock_bvalid", bus.b_valid, 1);
        chk("lock_noup", bus.dir_up, 0);
        chk("lock_locked", bus.locked, 1);
        cyc(1'b1, 1'b0, 3'b000, 1'b0);
        chk("idle_bvalid", bus.b_valid, 0);
        chk("idle_locked", bus.locked, 1);

        // Full up-count with wrap
        for (int i = 0; i < 8; i++) begin
            smp(up_seq[i]);
            chk("up_bout", bus.b_out, (i + 1) % 8);
            chk("up_pulse", bus.dir_up, 1);
        end
        chk("up_errcnt", bus.err_cnt, 0);

        // Down-count and hold
        smp(3'b100);
        chk("dn1_bout", bus.b_out, 7);
        chk("dn1_pulse", bus.dir_down, 1);
        smp(3'b100);
        chk("hold_bvalid", bus.b_valid, 1);
        chk("hold_nodn", bus.dir_down, 0);
        smp(3'b101);
        chk("dn2_bout", bus.b_out, 6);
        chk("dn2_pulse", bus.dir_down, 1);

        // Walk down to 2, then illegal step and recovery
        smp(3'b111); smp(3'b110); smp(3'b010); smp(3'b011);
        chk("walk_bout", bus.b_out, 2);
        smp(3'b111);
        chk("ill_err", bus.step_err, 1);
        chk("ill_cnt", bus.err_cnt, 1);
        chk("ill_bout", bus.b_out, 5);
        smp(3'b101);
        chk("rec_up", bus.dir_up, 1);
        chk("rec_locked", bus.locked, 1);

        // Fault and clear
        cyc(1'b1, 1'b0, 3'b000, 1'b1);
        chk("clr_cnt", bus.err_cnt, 0);
        chk("clr_locked", bus.locked, 0);
        smp(3'b000);
        chk("relock_bout", bus.b_out, 0);
        smp(3'b011);
        chk("f1_err", bus.step_err, 1);
        smp(3'b100);
        chk("f2_err", bus.step_err, 1);
        chk("f2_cnt", bus.err_cnt, 2);
        chk("f2_locked", bus.locked, 0);
        chk("f2_bout", bus.b_out, 7);
        smp(3'b000);
        chk("fault_ign_bv", bus.b_valid, 0);
        chk("fault_ign_bout", bus.b_out, 7);
        cyc(1'b1, 1'b1, 3'b001, 1'b1);
        chk("clrg_bv", bus.b_valid, 0);
        chk("clrg_cnt", bus.err_cnt, 0);
        chk("clrg_bout", bus.b_out, 7);
        smp(3'b001);
        chk("cap_bv", bus.b_valid, 1);
        chk("cap_bout", bus.b_out, 1);
        chk("cap_noup", bus.dir_up, 0);
        chk("cap_locked", bus.locked, 1);

        // Saturation: alternate bad and good steps so no fault occurs
        smp(3'b000);
        for (int k = 0; k < 130; k++) begin
            for (int j = 0; j < 4; j++) smp(sat_seq[j]);
        end
        chk("sat_cnt", bus.err_cnt, CNT_MAX);
        chk("sat_locked", bus.locked, 1);
        smp(3'b110);
        chk("sat_err", bus.step_err, 1);
        chk("sat_hold", bus.err_cnt, CNT_MAX);

        // Reset mid-stream
        cyc(1'b0, 1'b1, 3'b111, 1'b1);
        chk("mrst_bout", bus.b_out, 0);
        chk("mrst_cnt", bus.err_cnt, 0);
        chk("mrst_locked", bus.locked, 0);
        chk("mrst_bv", bus.b_valid, 0);
        smp(3'b111);
        chk("post_bout", bus.b_out, 5);
        chk("post_bv", bus.b_valid, 1);
        chk("post_noerr", bus.step_err, 0);
        chk("post_locked", bus.locked, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
